// File: rtl/yuv_pkg.sv
// Shared constants and types for the RGB to YCbCr 4:2:0 converter.
// BT.601 limited-range coefficients are 8.8 fixed point.
package yuv_pkg;

  localparam int C_COEF_W = 9;

  localparam logic signed [C_COEF_W-1:0] C_YR = 9'sd66;
  localparam logic signed [C_COEF_W-1:0] C_YG = 9'sd129;
  localparam logic signed [C_COEF_W-1:0] C_YB = 9'sd25;
  localparam logic signed [C_COEF_W-1:0] C_UR = -9'sd38;
  localparam logic signed [C_COEF_W-1:0] C_UG = -9'sd74;
  localparam logic signed [C_COEF_W-1:0] C_UB = 9'sd112;
  localparam logic signed [C_COEF_W-1:0] C_VR = 9'sd112;
  localparam logic signed [C_COEF_W-1:0] C_VG = -9'sd94;
  localparam logic signed [C_COEF_W-1:0] C_VB = -9'sd18;

  localparam int C_Y_OFS = 16;
  localparam int C_C_OFS = 128;
  localparam int C_Y_MIN = 16;
  localparam int C_Y_MAX = 235;
  localparam int C_C_MIN = 16;
  localparam int C_C_MAX = 240;
  localparam int C_ROUND = 128;

  localparam int C_Y_LAT = 3;
  localparam int C_C_LAT = 4;

  // Per-pixel sideband that rides alongside the conversion pipeline.
  typedef struct packed {
    logic eol;
    logic fend;
    logic cline;
    logic xodd;
  } pix_tag_t;

endpackage

// File: rtl/rgb2ycbcr_core.sv
// Three-stage RGB to YCbCr matrix: products, rounded sums with offsets,
// then clamp into the output registers. Valid follows the data unchanged.
module rgb2ycbcr_core
  import yuv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = C_COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_vld,
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] b,
  output logic              y_vld,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] cb,
  output logic [DATA_W-1:0] cr
);

  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int SUM_W  = PROD_W + 2;

  logic signed [PROD_W-1:0] yr_p0, yg_p0, yb_p0;
  logic signed [PROD_W-1:0] ur_p0, ug_p0, ub_p0;
  logic signed [PROD_W-1:0] vr_p0, vg_p0, vb_p0;
  logic signed [SUM_W-1:0]  y_p1, cb_p1, cr_p1;
  logic                     vld_p0, vld_p1;

  function automatic logic signed [PROD_W-1:0] mul(
    input logic [DATA_W-1:0]        px,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] k;
    a = PROD_W'(signed'({1'b0, px}));
    k = PROD_W'(c);
    return a * k;
  endfunction

  function automatic logic signed [SUM_W-1:0] round_ofs(
    input logic signed [SUM_W-1:0] acc,
    input int                      ofs
  );
    logic signed [SUM_W-1:0] t;
    t = (acc + SUM_W'(C_ROUND)) >>> 8;
    return t + SUM_W'(ofs);
  endfunction

  function automatic logic [DATA_W-1:0] sat(
    input logic signed [SUM_W-1:0] v,
    input int                      lo,
    input int                      hi
  );
    if (v < SUM_W'(lo)) return DATA_W'(lo);
    if (v > SUM_W'(hi)) return DATA_W'(hi);
    return v[DATA_W-1:0];
  endfunction

  // Stage 1: coefficient products
  always_ff @(posedge clk) begin
    yr_p0 <= mul(r, C_YR);
    yg_p0 <= mul(g, C_YG);
    yb_p0 <= mul(b, C_YB);
    ur_p0 <= mul(r, C_UR);
    ug_p0 <= mul(g, C_UG);
    ub_p0 <= mul(b, C_UB);
    vr_p0 <= mul(r, C_VR);
    vg_p0 <= mul(g, C_VG);
    vb_p0 <= mul(b, C_VB);
  end

  // Stage 2: sums, rounding and offsets
  always_ff @(posedge clk) begin
    y_p1  <= round_ofs(SUM_W'(yr_p0) + SUM_W'(yg_p0) + SUM_W'(yb_p0), C_Y_OFS);
    cb_p1 <= round_ofs(SUM_W'(ur_p0) + SUM_W'(ug_p0) + SUM_W'(ub_p0), C_C_OFS);
    cr_p1 <= round_ofs(SUM_W'(vr_p0) + SUM_W'(vg_p0) + SUM_W'(vb_p0), C_C_OFS);
  end

  // Stage 3: clamp into the output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      y_vld  <= 1'b0;
      y      <= '0;
      cb     <= '0;
      cr     <= '0;
    end else begin
      vld_p0 <= pix_vld;
      vld_p1 <= vld_p0;
      y_vld  <= vld_p1;
      if (vld_p1) begin
        y  <= sat(y_p1, C_Y_MIN, C_Y_MAX);
        cb <= sat(cb_p1, C_C_MIN, C_C_MAX);
        cr <= sat(cr_p1, C_C_MIN, C_C_MAX);
      end
    end
  end

endmodule

// File: rtl/rgb_to_yuv420.sv
// RGB to YCbCr 4:2:0 front end for the encoder: full-rate luma, horizontally
// averaged chroma on one line parity, and EOL / frame-end markers.
module rgb_to_yuv420
  import yuv_pkg::*;
#(
  parameter int G_DATA_WIDTH       = 8,
  parameter int G_RES_WIDTH        = 13,
  parameter int G_CHROMA_ODD_LINES = 0
) (
  input  logic                    SYS_CLK_I,
  input  logic                    RESET_I,
  input  logic                    FRAME_START_I,
  input  logic [G_RES_WIDTH-1:0]  HRES_I,
  input  logic [G_RES_WIDTH-1:0]  VRES_I,
  input  logic                    DATA_VALID_I,
  input  logic [G_DATA_WIDTH-1:0] DATA_R_I,
  input  logic [G_DATA_WIDTH-1:0] DATA_G_I,
  input  logic [G_DATA_WIDTH-1:0] DATA_B_I,
  output logic                    Y_VALID_O,
  output logic [G_DATA_WIDTH-1:0] Y_O,
  output logic                    C_VALID_O,
  output logic [G_DATA_WIDTH-1:0] CB_O,
  output logic [G_DATA_WIDTH-1:0] CR_O,
  output logic                    EOL_O,
  output logic                    FRAME_END_O
);

  localparam int   RW    = G_RES_WIDTH;
  localparam int   DW    = G_DATA_WIDTH;
  localparam logic C_PAR = (G_CHROMA_ODD_LINES != 0);

  logic [RW-1:0] hres_q, vres_q, x_cnt, y_cnt;
  logic [RW-1:0] hres_eff, vres_eff, x_cur, y_cur;
  logic          last_x, last_y;
  pix_tag_t      tag_in, tag_p0, tag_p1, tag_p2;
  logic [DW-1:0] c_cb, c_cr, pend_cb, pend_cr;
  logic          pend_vld;

  function automatic logic [RW-1:0] res_floor(input logic [RW-1:0] v);
    return (v < RW'(2)) ? RW'(2) : v;
  endfunction

  function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] c);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, c} + (DW+1)'(1);
    return s[DW:1];
  endfunction

  // A pixel arriving with FRAME_START_I belongs to the new frame at (0,0).
  assign hres_eff = res_floor(FRAME_START_I ? HRES_I : hres_q);
  assign vres_eff = res_floor(FRAME_START_I ? VRES_I : vres_q);
  assign x_cur    = FRAME_START_I ? '0 : x_cnt;
  assign y_cur    = FRAME_START_I ? '0 : y_cnt;
  assign last_x   = (x_cur == hres_eff - RW'(1));
  assign last_y   = (y_cur == vres_eff - RW'(1));
  assign tag_in   = '{eol: last_x, fend: last_x && last_y,
                      cline: (y_cur[0] == C_PAR), xodd: x_cur[0]};

  always_ff @(posedge SYS_CLK_I) begin
    if (RESET_I) begin
      hres_q <= '0;
      vres_q <= '0;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else begin
      if (FRAME_START_I) begin
        hres_q <= res_floor(HRES_I);
        vres_q <= res_floor(VRES_I);
      end
      if (DATA_VALID_I) begin
        if (last_x) begin
          x_cnt <= '0;
          y_cnt <= last_y ? '0 : y_cur + RW'(1);
        end else begin
          x_cnt <= x_cur + RW'(1);
          y_cnt <= y_cur;
        end
      end else if (FRAME_START_I) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end
    end
  end

  rgb2ycbcr_core #(
    .DATA_W (DW),
    .COEF_W (C_COEF_W)
  ) u_core (
    .clk     (SYS_CLK_I),
    .rst     (RESET_I),
    .pix_vld (DATA_VALID_I),
    .r       (DATA_R_I),
    .g       (DATA_G_I),
    .b       (DATA_B_I),
    .y_vld   (Y_VALID_O),
    .y       (Y_O),
    .cb      (c_cb),
    .cr      (c_cr)
  );

  // Stages 1-3: sideband tags kept in step with the core pipeline
  always_ff @(posedge SYS_CLK_I) begin
    tag_p0 <= tag_in;
    tag_p1 <= tag_p0;
    tag_p2 <= tag_p1;
  end

  assign EOL_O       = Y_VALID_O && tag_p2.eol;
  assign FRAME_END_O = Y_VALID_O && tag_p2.fend;

  // Stage 4: chroma pairing; an even pixel closing a line is never held
  always_ff @(posedge SYS_CLK_I) begin
    if (RESET_I) begin
      C_VALID_O <= 1'b0;
      CB_O      <= '0;
      CR_O      <= '0;
      pend_vld  <= 1'b0;
    end else begin
      C_VALID_O <= 1'b0;
      if (Y_VALID_O && tag_p2.cline && tag_p2.xodd && pend_vld) begin
        C_VALID_O <= 1'b1;
        CB_O      <= avg(pend_cb, c_cb);
        CR_O      <= avg(pend_cr, c_cr);
      end
      if (FRAME_START_I)
        pend_vld <= 1'b0;
      else if (Y_VALID_O && tag_p2.cline && !tag_p2.xodd && !tag_p2.eol)
        pend_vld <= 1'b1;
      else if (Y_VALID_O)
        pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK_I) begin
    if (Y_VALID_O && tag_p2.cline && !tag_p2.xodd) begin
      pend_cb <= c_cb;
      pend_cr <= c_cr;
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv420.sv
// Directed bench for rgb_to_yuv420: an even-line and an odd-line chroma
// instance share the same stimulus and are checked against fixed tables.
module tb_rgb_to_yuv420;
  import yuv_pkg::*;

  typedef int seq_t [12];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs  = 1'b0;
  logic        dv  = 1'b0;
  logic [12:0] hres = '0;
  logic [12:0] vres = '0;
  logic [7:0]  r = '0, g = '0, b = '0;

  logic       yv  [2];
  logic [7:0] yo  [2];
  logic       cv  [2];
  logic [7:0] cbo [2];
  logic [7:0] cro [2];
  logic       eol [2];
  logic       fe  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rgb_to_yuv420 #(.G_DATA_WIDTH(8), .G_RES_WIDTH(13), .G_CHROMA_ODD_LINES(0)) dut0 (
    .SYS_CLK_I(clk), .RESET_I(rst), .FRAME_START_I(fs), .HRES_I(hres), .VRES_I(vres),
    .DATA_VALID_I(dv), .DATA_R_I(r), .DATA_G_I(g), .DATA_B_I(b),
    .Y_VALID_O(yv[0]), .Y_O(yo[0]), .C_VALID_O(cv[0]), .CB_O(cbo[0]), .CR_O(cro[0]),
    .EOL_O(eol[0]), .FRAME_END_O(fe[0])
  );

  rgb_to_yuv420 #(.G_DATA_WIDTH(8), .G_RES_WIDTH(13), .G_CHROMA_ODD_LINES(1)) dut1 (
    .SYS_CLK_I(clk), .RESET_I(rst), .FRAME_START_I(fs), .HRES_I(hres), .VRES_I(vres),
    .DATA_VALID_I(dv), .DATA_R_I(r), .DATA_G_I(g), .DATA_B_I(b),
    .Y_VALID_O(yv[1]), .Y_O(yo[1]), .C_VALID_O(cv[1]), .CB_O(cbo[1]), .CR_O(cro[1]),
    .EOL_O(eol[1]), .FRAME_END_O(fe[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string s, input int d);
    chk({s, "_yv"},  32'(yv[d]),  32'd0);
    chk({s, "_y"},   32'(yo[d]),  32'd0);
    chk({s, "_cv"},  32'(cv[d]),  32'd0);
    chk({s, "_cb"},  32'(cbo[d]), 32'd0);
    chk({s, "_cr"},  32'(cro[d]), 32'd0);
    chk({s, "_eol"}, 32'(eol[d]), 32'd0);
    chk({s, "_fe"},  32'(fe[d]),  32'd0);
  endtask

  // Colour codes: 0 white, 1 red, 2 black, 3 blue, -1 no pixel.
  task automatic set_col(input int k);
    case (k)
      0:       begin r = 8'd255; g = 8'd255; b = 8'd255; end
      1:       begin r = 8'd255; g = 8'd0;   b = 8'd0;   end
      3:       begin r = 8'd0;   g = 8'd0;   b = 8'd255; end
      default: begin r = 8'd0;   g = 8'd0;   b = 8'd0;   end
    endcase
  endtask

  // Chroma expectations are packed as {cb, cr} in hex, -1 for no output.
  task automatic run(input string s, input seq_t fsq, input seq_t col, input seq_t ey,
                     input seq_t eeol, input seq_t efe, input seq_t ec0, input seq_t ec1);
    for (int c = 0; c < 8 + C_C_LAT; c++) begin
      fs = (fsq[c] != 0);
      dv = (col[c] >= 0);
      set_col(col[c]);
      tick();
      for (int d = 0; d < 2; d++) begin
        string t;
        int    ec;
        t  = $sformatf("%s_c%0d_d%0d", s, c, d);
        ec = (d == 0) ? ec0[c] : ec1[c];
        chk({t, "_yv"}, 32'(yv[d]), 32'(ey[c] >= 0));
        if (ey[c] >= 0) chk({t, "_y"}, 32'(yo[d]), 32'(ey[c]));
        chk({t, "_eol"}, 32'(eol[d]), 32'(eeol[c] != 0));
        chk({t, "_fe"},  32'(fe[d]),  32'(efe[c] != 0));
        chk({t, "_cv"},  32'(cv[d]),  32'(ec >= 0));
        if (ec >= 0) begin
          chk({t, "_cb"}, 32'(cbo[d]), 32'((ec >> 8) & 255));
          chk({t, "_cr"}, 32'(cro[d]), 32'(ec & 255));
        end
      end
    end
    fs = 1'b0;
    dv = 1'b0;
  endtask

  initial begin
    seq_t fsq, col, ey, eeol, efe, ec0, ec1;

    // Reset state
    rst = 1'b1;
    repeat (C_Y_LAT) tick();
    chk_all_zero("rst_d0", 0);
    chk_all_zero("rst_d1", 1);
    rst = 1'b0;

    // Eight white pixels, 4x2 frame
    hres = 13'd4;
    vres = 13'd2;
    fsq  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    col  = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1};
    ey   = '{-1, -1, -1, 235, 235, 235, 235, 235, 235, 235, 235, -1};
    eeol = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    efe  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    ec0  = '{-1, -1, -1, -1, -1, 'h8080, -1, 'h8080, -1, -1, -1, -1};
    ec1  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 'h8080, -1, 'h8080};
    run("white", fsq, col, ey, eeol, efe, ec0, ec1);

    // Red/black pair on line 0 after the frame wrapped
    fsq  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    col  = '{1, 2, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    ey   = '{-1, -1, 82, 16, -1, -1, -1, -1, -1, -1, -1, -1};
    eeol = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    efe  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ec0  = '{-1, -1, -1, -1, 'h6DB8, -1, -1, -1, -1, -1, -1, -1};
    ec1  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    run("redblk", fsq, col, ey, eeol, efe, ec0, ec1);

    // Odd HRES=3 blue line, frame start coincident with the first pixel
    hres = 13'd3;
    fsq  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    col  = '{3, 3, 3, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    ey   = '{-1, -1, 41, 41, 41, -1, -1, -1, -1, -1, -1, -1};
    eeol = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    efe  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ec0  = '{-1, -1, -1, -1, 'hF06E, -1, -1, -1, -1, -1, -1, -1};
    ec1  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    run("blue3", fsq, col, ey, eeol, efe, ec0, ec1);

    // Mid-line abort: one red pixel, new frame, then a full line
    hres = 13'd4;
    fsq  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    col  = '{-1, 1, -1, 2, 0, 1, 2, -1, -1, -1, -1, -1};
    ey   = '{-1, -1, -1, 82, -1, 16, 235, 82, 16, -1, -1, -1};
    eeol = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    efe  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ec0  = '{-1, -1, -1, -1, -1, -1, -1, 'h8080, -1, 'h6DB8, -1, -1};
    ec1  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    run("abort", fsq, col, ey, eeol, efe, ec0, ec1);

    // Valid gaps on line 1 (last line of the frame)
    fsq  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    col  = '{0, -1, 1, -1, 2, -1, 0, -1, -1, -1, -1, -1};
    ey   = '{-1, -1, 235, -1, 82, -1, 16, -1, 235, -1, -1, -1};
    eeol = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    efe  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    ec0  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    ec1  = '{-1, -1, -1, -1, -1, 'h6DB8, -1, -1, -1, 'h8080, -1, -1};
    run("gaps", fsq, col, ey, eeol, efe, ec0, ec1);

    // Reset with pixels in flight
    fs = 1'b1;
    dv = 1'b1;
    set_col(0);
    tick();
    fs = 1'b0;
    tick();
    tick();
    tick();
    chk("inflight_yv", 32'(yv[0]), 32'd1);
    chk("inflight_y",  32'(yo[0]), 32'd235);
    rst = 1'b1;
    dv  = 1'b0;
    tick();
    chk_all_zero("midrst_d0", 0);
    chk_all_zero("midrst_d1", 1);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("postrst_c%0d_d%0d_yv", c, d), 32'(yv[d]), 32'd0);
        chk($sformatf("postrst_c%0d_d%0d_cv", c, d), 32'(cv[d]), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
